// File: rtl/writeback_stage_pkg.sv
// Shared constants for the writeback stage: datasize codes, EFLAGS bit
// positions, control-store bit positions, the EX/WB latch payload and the
// store FSM state encodings.
package writeback_stage_pkg;

    // Datasize encodings carried down from decode.
    localparam logic [1:0] DS_BYTE  = 2'b00;
    localparam logic [1:0] DS_WORD  = 2'b01;
    localparam logic [1:0] DS_DWORD = 2'b10;
    localparam logic [1:0] DS_QWORD = 2'b11;

    // EFLAGS layout.
    localparam int unsigned  EFLAGS_ZF_BIT = 6;
    localparam logic [31:0]  EFLAGS_RESET  = 32'h0000_0002;

    // Control-store bit that requests an EFLAGS update at writeback.
    localparam int unsigned  CS_LD_FLAGS_WB = 37;

    // Store FSM states.
    localparam logic [1:0] MEM_IDLE = 2'b00;
    localparam logic [1:0] MEM_WAIT = 2'b01;
    localparam logic [1:0] MEM_DONE = 2'b10;

    // Payload held in the EX/WB latch (valid bit is kept separately).
    typedef struct packed {
        logic        ld_flags;
        logic [1:0]  ds;
        logic        ld_gpr1;
        logic        ld_gpr2;
        logic        ld_mm;
        logic        dcache_write;
        logic        repne;
        logic [31:0] res_a;
        logic [31:0] res_b;
        logic [31:0] res_c;
        logic [31:0] flags;
        logic [63:0] res_mm;
        logic [2:0]  dr1;
        logic [2:0]  dr2;
        logic [31:0] addr;
    } wb_latch_t;

    // Qword size selects the MMX datapath.
    function automatic logic is_qword(input logic [1:0] ds);
        return ds == DS_QWORD;
    endfunction

endpackage

// File: rtl/writeback_stage_store_ctrl.sv
// Store controller for the writeback stage: tracks whether the current uop's
// dcache store is still outstanding, drives the request and the stage stall.
//
// Handshake: dcache_wr_req rises when a valid store uop sits in the latch and
// stays high (address/data/size stable) until dcache_wr_ack; ack may arrive in
// the same cycle as the first req. After the ack the FSM parks in DONE so the
// same uop never issues a second store.
module wb_store_ctrl
    import writeback_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       v,
    input  logic       dcache_write,
    input  logic       ack,
    input  logic       ld_eff,
    output logic       dcache_wr_req,
    output logic       wb_stall,
    output logic [1:0] mem_st
);

    logic [1:0] mem_st_q;
    logic [1:0] mem_st_d;

    // Next-state: a new latch load always restarts from IDLE, so an ack that
    // coincides with a load never leaves the fresh uop marked as stored.
    always_comb begin
        mem_st_d = mem_st_q;
        if (ld_eff) begin
            mem_st_d = MEM_IDLE;
        end else begin
            case (mem_st_q)
                MEM_IDLE: if (v && dcache_write) mem_st_d = ack ? MEM_DONE : MEM_WAIT;
                MEM_WAIT: begin
                    if (!v)      mem_st_d = MEM_IDLE;
                    else if (ack) mem_st_d = MEM_DONE;
                end
                MEM_DONE: if (!v) mem_st_d = MEM_IDLE;
                default:  mem_st_d = MEM_IDLE;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) mem_st_q <= MEM_IDLE;
        else     mem_st_q <= mem_st_d;
    end

    assign dcache_wr_req = v & dcache_write & (mem_st_q != MEM_DONE);
    assign wb_stall      = dcache_wr_req & ~ack;
    assign mem_st        = mem_st_q;

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: EX/WB latch, single retire per uop, GPR/MM/EFLAGS writes,
// dcache store issue via wb_store_ctrl, REPNE termination and flag forwarding.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int unsigned ZF_BIT   = EFLAGS_ZF_BIT,
    parameter logic [31:0] FLAGS_RV = EFLAGS_RESET
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         WB_ld_latches,
    input  logic         WB_V_next,
    input  logic [127:0] WB_CONTROL_STORE_next,
    input  logic [1:0]   WB_d2_datasize_all_next,
    input  logic         WB_ex_ld_gpr1_wb_next,
    input  logic         WB_ex_ld_gpr2_wb_next,
    input  logic         WB_ex_ld_mm_wb_next,
    input  logic         WB_ex_dcache_write_wb_next,
    input  logic         WB_d2_repne_wb_next,
    input  logic [31:0]  WB_RESULT_A_next,
    input  logic [31:0]  WB_RESULT_B_next,
    input  logic [31:0]  WB_RESULT_C_next,
    input  logic [31:0]  WB_FLAGS_next,
    input  logic [63:0]  WB_RESULT_MM_next,
    input  logic [2:0]   WB_DR1_next,
    input  logic [2:0]   WB_DR2_next,
    input  logic [31:0]  WB_ADDRESS_next,
    input  logic         dcache_wr_ack,
    output logic         gpr_we1,
    output logic         gpr_we2,
    output logic [2:0]   gpr_wa1,
    output logic [2:0]   gpr_wa2,
    output logic [31:0]  gpr_wd1,
    output logic [31:0]  gpr_wd2,
    output logic [1:0]   gpr_ws,
    output logic         mm_we,
    output logic [2:0]   mm_wa,
    output logic [63:0]  mm_wd,
    output logic         dcache_wr_req,
    output logic [31:0]  dcache_wr_addr,
    output logic [63:0]  dcache_wr_data,
    output logic [1:0]   dcache_wr_size,
    output logic         WB_stall,
    output logic         wb_repne_terminate_all,
    output logic [31:0]  saved_count,
    output logic [31:0]  flags_dataforwarded
);

    localparam logic [4:0] ZF_IDX = 5'(ZF_BIT);

    wb_latch_t   lat_q, lat_d, lat_next;
    logic        v_q, v_d;
    logic        retired_q, retired_d;
    logic [31:0] eflags_q, eflags_d;
    logic [31:0] saved_count_q, saved_count_d;
    logic        ld_eff;
    logic        retire;
    logic        qword;
    logic        repne_term;
    logic        unused_cs;
    logic [1:0]  unused_mem_st;

    // Only the flags-load bit of the control word matters here.
    assign unused_cs = ^{WB_CONTROL_STORE_next[127:CS_LD_FLAGS_WB+1],
                         WB_CONTROL_STORE_next[CS_LD_FLAGS_WB-1:0]};

    assign ld_eff = WB_ld_latches & ~WB_stall;

    // Store FSM; its state net stays visible in the hierarchy for checkers.
    wb_store_ctrl u_store_ctrl (
        .clk           (CLK),
        .rst           (RST),
        .v             (v_q),
        .dcache_write  (lat_q.dcache_write),
        .ack           (dcache_wr_ack),
        .ld_eff        (ld_eff),
        .dcache_wr_req (dcache_wr_req),
        .wb_stall      (WB_stall),
        .mem_st        (unused_mem_st)
    );

    // Pack the incoming execute results into the latch payload.
    always_comb begin
        lat_next              = '0;
        lat_next.ld_flags     = WB_CONTROL_STORE_next[CS_LD_FLAGS_WB];
        lat_next.ds           = WB_d2_datasize_all_next;
        lat_next.ld_gpr1      = WB_ex_ld_gpr1_wb_next;
        lat_next.ld_gpr2      = WB_ex_ld_gpr2_wb_next;
        lat_next.ld_mm        = WB_ex_ld_mm_wb_next;
        lat_next.dcache_write = WB_ex_dcache_write_wb_next;
        lat_next.repne        = WB_d2_repne_wb_next;
        lat_next.res_a        = WB_RESULT_A_next;
        lat_next.res_b        = WB_RESULT_B_next;
        lat_next.res_c        = WB_RESULT_C_next;
        lat_next.flags        = WB_FLAGS_next;
        lat_next.res_mm       = WB_RESULT_MM_next;
        lat_next.dr1          = WB_DR1_next;
        lat_next.dr2          = WB_DR2_next;
        lat_next.addr         = WB_ADDRESS_next;
    end

    // A reset cycle never retires, even if an ack shows up during it.
    assign retire     = v_q & ~WB_stall & ~retired_q & ~RST;
    assign qword      = is_qword(lat_q.ds);
    assign repne_term = (lat_q.res_c == 32'h0) | lat_q.flags[ZF_IDX];

    // Next-state for latch, retire marker, EFLAGS and the REPNE count.
    always_comb begin
        v_d           = v_q;
        lat_d         = lat_q;
        retired_d     = retired_q;
        eflags_d      = eflags_q;
        saved_count_d = saved_count_q;
        if (retire) begin
            retired_d = 1'b1;
            if (lat_q.ld_flags) eflags_d      = lat_q.flags;
            if (lat_q.repne)    saved_count_d = lat_q.res_c;
        end
        if (ld_eff) begin
            v_d       = WB_V_next;
            lat_d     = lat_next;
            retired_d = 1'b0;
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            v_q           <= 1'b0;
            lat_q         <= '0;
            retired_q     <= 1'b0;
            eflags_q      <= FLAGS_RV;
            saved_count_q <= 32'h0;
        end else begin
            v_q           <= v_d;
            lat_q         <= lat_d;
            retired_q     <= retired_d;
            eflags_q      <= eflags_d;
            saved_count_q <= saved_count_d;
        end
    end

    // Register-file writes fire in the retire cycle; qword GPR writes are dropped.
    // A REPNE uop writes its decremented count through port 2.
    assign gpr_we1 = retire & lat_q.ld_gpr1 & ~qword;
    assign gpr_we2 = retire & lat_q.ld_gpr2 & ~qword;
    assign gpr_wa1 = lat_q.dr1;
    assign gpr_wa2 = lat_q.dr2;
    assign gpr_wd1 = lat_q.res_a;
    assign gpr_wd2 = lat_q.repne ? lat_q.res_c : lat_q.res_b;
    assign gpr_ws  = lat_q.ds;

    assign mm_we = retire & lat_q.ld_mm;
    assign mm_wa = lat_q.dr1;
    assign mm_wd = lat_q.res_mm;

    assign dcache_wr_addr = lat_q.addr;
    assign dcache_wr_data = qword ? lat_q.res_mm : {32'h0, lat_q.res_a};
    assign dcache_wr_size = lat_q.ds;

    assign wb_repne_terminate_all = retire & lat_q.repne & repne_term;
    assign saved_count            = saved_count_q;
    assign flags_dataforwarded    = (v_q & lat_q.ld_flags & ~retired_q) ? lat_q.flags : eflags_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios followed by
// random uops, each compared against a reference model of the stage's rules.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    logic         CLK = 1'b0;
    logic         RST;
    logic         WB_ld_latches;
    logic         WB_V_next;
    logic [127:0] WB_CONTROL_STORE_next;
    logic [1:0]   WB_d2_datasize_all_next;
    logic         WB_ex_ld_gpr1_wb_next;
    logic         WB_ex_ld_gpr2_wb_next;
    logic         WB_ex_ld_mm_wb_next;
    logic         WB_ex_dcache_write_wb_next;
    logic         WB_d2_repne_wb_next;
    logic [31:0]  WB_RESULT_A_next, WB_RESULT_B_next, WB_RESULT_C_next;
    logic [31:0]  WB_FLAGS_next;
    logic [63:0]  WB_RESULT_MM_next;
    logic [2:0]   WB_DR1_next, WB_DR2_next;
    logic [31:0]  WB_ADDRESS_next;
    logic         dcache_wr_ack;
    logic         gpr_we1, gpr_we2;
    logic [2:0]   gpr_wa1, gpr_wa2;
    logic [31:0]  gpr_wd1, gpr_wd2;
    logic [1:0]   gpr_ws;
    logic         mm_we;
    logic [2:0]   mm_wa;
    logic [63:0]  mm_wd;
    logic         dcache_wr_req;
    logic [31:0]  dcache_wr_addr;
    logic [63:0]  dcache_wr_data;
    logic [1:0]   dcache_wr_size;
    logic         WB_stall;
    logic         wb_repne_terminate_all;
    logic [31:0]  saved_count;
    logic [31:0]  flags_dataforwarded;

    int checks = 0;
    int errors = 0;

    // Reference model architectural state.
    logic [31:0] eflags_m;
    logic [31:0] saved_m;

    typedef struct {
        bit          v, cs, ld_gpr1, ld_gpr2, ld_mm, st, repne;
        logic [1:0]  ds;
        logic [31:0] a, b, c, flags, addr;
        logic [63:0] mm;
        logic [2:0]  dr1, dr2;
    } uop_t;

    writeback_stage dut (
        .CLK(CLK), .RST(RST), .WB_ld_latches(WB_ld_latches), .WB_V_next(WB_V_next),
        .WB_CONTROL_STORE_next(WB_CONTROL_STORE_next),
        .WB_d2_datasize_all_next(WB_d2_datasize_all_next),
        .WB_ex_ld_gpr1_wb_next(WB_ex_ld_gpr1_wb_next),
        .WB_ex_ld_gpr2_wb_next(WB_ex_ld_gpr2_wb_next),
        .WB_ex_ld_mm_wb_next(WB_ex_ld_mm_wb_next),
        .WB_ex_dcache_write_wb_next(WB_ex_dcache_write_wb_next),
        .WB_d2_repne_wb_next(WB_d2_repne_wb_next),
        .WB_RESULT_A_next(WB_RESULT_A_next), .WB_RESULT_B_next(WB_RESULT_B_next),
        .WB_RESULT_C_next(WB_RESULT_C_next), .WB_FLAGS_next(WB_FLAGS_next),
        .WB_RESULT_MM_next(WB_RESULT_MM_next), .WB_DR1_next(WB_DR1_next),
        .WB_DR2_next(WB_DR2_next), .WB_ADDRESS_next(WB_ADDRESS_next),
        .dcache_wr_ack(dcache_wr_ack),
        .gpr_we1(gpr_we1), .gpr_we2(gpr_we2), .gpr_wa1(gpr_wa1), .gpr_wa2(gpr_wa2),
        .gpr_wd1(gpr_wd1), .gpr_wd2(gpr_wd2), .gpr_ws(gpr_ws),
        .mm_we(mm_we), .mm_wa(mm_wa), .mm_wd(mm_wd),
        .dcache_wr_req(dcache_wr_req), .dcache_wr_addr(dcache_wr_addr),
        .dcache_wr_data(dcache_wr_data), .dcache_wr_size(dcache_wr_size),
        .WB_stall(WB_stall), .wb_repne_terminate_all(wb_repne_terminate_all),
        .saved_count(saved_count), .flags_dataforwarded(flags_dataforwarded)
    );

    // Clock and a global time limit.
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic uop_t rand_uop();
        uop_t u;
        u.v       = 1'b1;
        u.cs      = 1'($urandom_range(0, 1));
        u.ds      = 2'($urandom_range(0, 3));
        u.ld_gpr1 = 1'($urandom_range(0, 1));
        u.ld_gpr2 = 1'($urandom_range(0, 1));
        u.ld_mm   = 1'($urandom_range(0, 1));
        u.st      = 1'($urandom_range(0, 1));
        u.repne   = 1'($urandom_range(0, 1));
        u.a       = $urandom;
        u.b       = $urandom;
        u.c       = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        u.flags   = $urandom;
        u.addr    = $urandom;
        u.mm      = {$urandom, $urandom};
        u.dr1     = 3'($urandom_range(0, 7));
        u.dr2     = 3'($urandom_range(0, 7));
        return u;
    endfunction

    task automatic drive_next(input uop_t u);
        WB_V_next                  = u.v;
        WB_CONTROL_STORE_next      = '0;
        WB_CONTROL_STORE_next[CS_LD_FLAGS_WB] = u.cs;
        WB_d2_datasize_all_next    = u.ds;
        WB_ex_ld_gpr1_wb_next      = u.ld_gpr1;
        WB_ex_ld_gpr2_wb_next      = u.ld_gpr2;
        WB_ex_ld_mm_wb_next        = u.ld_mm;
        WB_ex_dcache_write_wb_next = u.st;
        WB_d2_repne_wb_next        = u.repne;
        WB_RESULT_A_next           = u.a;
        WB_RESULT_B_next           = u.b;
        WB_RESULT_C_next           = u.c;
        WB_FLAGS_next              = u.flags;
        WB_RESULT_MM_next          = u.mm;
        WB_DR1_next                = u.dr1;
        WB_DR2_next                = u.dr2;
        WB_ADDRESS_next            = u.addr;
    endtask

    // Architectural effect of retiring u.
    task automatic model_retire(input uop_t u);
        if (u.cs)    eflags_m = u.flags;
        if (u.repne) saved_m  = u.c;
    endtask

    // Compare every output for one cycle of uop u.
    task automatic check_cycle(input uop_t u, input bit retire_now, input bit exp_req,
                               input bit exp_stall, input bit retired_before);
        bit          we1_e, we2_e, mm_e, term_e;
        logic [63:0] data_e;
        logic [31:0] fwd_e;
        we1_e  = retire_now && u.ld_gpr1 && (u.ds != DS_QWORD);
        we2_e  = retire_now && u.ld_gpr2 && (u.ds != DS_QWORD);
        mm_e   = retire_now && u.ld_mm;
        term_e = retire_now && u.repne && ((u.c == 0) || u.flags[EFLAGS_ZF_BIT]);
        data_e = (u.ds == DS_QWORD) ? u.mm : {32'h0, u.a};
        fwd_e  = (u.cs && !retired_before) ? u.flags : eflags_m;
        check("stall", 64'(WB_stall), 64'(exp_stall));
        check("req", 64'(dcache_wr_req), 64'(exp_req));
        if (exp_req) begin
            check("st_addr", 64'(dcache_wr_addr), 64'(u.addr));
            check("st_size", 64'(dcache_wr_size), 64'(u.ds));
            check("st_data", dcache_wr_data, data_e);
        end
        check("we1", 64'(gpr_we1), 64'(we1_e));
        if (we1_e) begin
            check("wa1", 64'(gpr_wa1), 64'(u.dr1));
            check("wd1", 64'(gpr_wd1), 64'(u.a));
            check("ws", 64'(gpr_ws), 64'(u.ds));
        end
        check("we2", 64'(gpr_we2), 64'(we2_e));
        if (we2_e) begin
            check("wa2", 64'(gpr_wa2), 64'(u.dr2));
            check("wd2", 64'(gpr_wd2), 64'(u.repne ? u.c : u.b));
        end
        check("mm_we", 64'(mm_we), 64'(mm_e));
        if (mm_e) begin
            check("mm_wa", 64'(mm_wa), 64'(u.dr1));
            check("mm_wd", mm_wd, u.mm);
        end
        check("terminate", 64'(wb_repne_terminate_all), 64'(term_e));
        check("flags_fwd", 64'(flags_dataforwarded), 64'(fwd_e));
        check("saved_count", 64'(saved_count), 64'(saved_m));
    endtask

    // Load u, ack its store d cycles after the first req, check each cycle and
    // one cycle past retire. poke_ld attempts extra loads while stalled.
    task automatic run_uop(input uop_t u, input int d, input bit poke_ld);
        int ncyc;
        bit retired;
        ncyc    = u.st ? d + 1 : 1;
        retired = 1'b0;
        @(negedge CLK);
        drive_next(u);
        WB_ld_latches = 1'b1;
        dcache_wr_ack = 1'b0;
        for (int k = 0; k <= ncyc; k++) begin
            @(negedge CLK);
            WB_ld_latches = 1'b0;
            if (poke_ld && (k < ncyc - 1)) begin
                drive_next(rand_uop());
                WB_ld_latches = 1'b1;
            end
            dcache_wr_ack = u.st && (k == d);
            #1;
            check_cycle(u, k == ncyc - 1, u.st && (k < ncyc), u.st && (k < ncyc - 1), retired);
            if (k == ncyc - 1) begin
                model_retire(u);
                retired = 1'b1;
            end
        end
        dcache_wr_ack = 1'b0;
    endtask

    task automatic run_bubble();
        uop_t u;
        u   = rand_uop();
        u.v = 1'b0;
        @(negedge CLK);
        drive_next(u);
        WB_ld_latches = 1'b1;
        @(negedge CLK);
        WB_ld_latches = 1'b0;
        #1;
        check("bub_we1", 64'(gpr_we1), 64'(0));
        check("bub_we2", 64'(gpr_we2), 64'(0));
        check("bub_mm_we", 64'(mm_we), 64'(0));
        check("bub_req", 64'(dcache_wr_req), 64'(0));
        check("bub_stall", 64'(WB_stall), 64'(0));
        check("bub_flags_fwd", 64'(flags_dataforwarded), 64'(eflags_m));
    endtask

    // Directed steps then random traffic.
    initial begin
        uop_t u, a, b;
        RST           = 1'b1;
        WB_ld_latches = 1'b0;
        dcache_wr_ack = 1'b0;
        u   = rand_uop();
        u.v = 1'b0;
        drive_next(u);
        eflags_m = EFLAGS_RESET;
        saved_m  = 32'h0;

        // Reset held two cycles, then idle.
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst_we1", 64'(gpr_we1), 64'(0));
        check("rst_we2", 64'(gpr_we2), 64'(0));
        check("rst_mm_we", 64'(mm_we), 64'(0));
        check("rst_req", 64'(dcache_wr_req), 64'(0));
        check("rst_stall", 64'(WB_stall), 64'(0));
        check("rst_term", 64'(wb_repne_terminate_all), 64'(0));
        check("rst_flags_fwd", 64'(flags_dataforwarded), 64'(32'h2));
        check("rst_saved", 64'(saved_count), 64'(0));

        // ALU uop writing GPR 3.
        u = rand_uop();
        u.cs = 0; u.ds = DS_DWORD; u.ld_gpr1 = 1; u.ld_gpr2 = 0; u.ld_mm = 0;
        u.st = 0; u.repne = 0; u.dr1 = 3'd3; u.a = 32'h1234;
        run_uop(u, 0, 0);

        // Store acked on the third request cycle, extra loads while stalled.
        u = rand_uop();
        u.st = 1; u.addr = 32'h1000; u.ds = DS_DWORD; u.ld_gpr1 = 1; u.repne = 0;
        run_uop(u, 2, 1);

        // REPNE count 5, ZF clear: no terminate, saved_count becomes 5.
        u = rand_uop();
        u.st = 0; u.repne = 1; u.c = 32'd5; u.flags = 32'h2; u.ld_gpr2 = 1; u.ds = DS_DWORD;
        run_uop(u, 0, 0);
        // REPNE count 0: terminate.
        u.c = 32'd0;
        run_uop(u, 0, 0);
        // REPNE count 7 with ZF set: terminate.
        u.c = 32'd7; u.flags = 32'h42;
        run_uop(u, 0, 0);

        // Flag forwarding across a stalled store.
        u = rand_uop();
        u.cs = 1; u.flags = 32'h46; u.st = 1; u.repne = 0;
        run_uop(u, 1, 0);

        // Qword with GPR write requests: GPR writes suppressed, MM write kept.
        u = rand_uop();
        u.ds = DS_QWORD; u.ld_gpr1 = 1; u.ld_gpr2 = 1; u.ld_mm = 1; u.st = 1;
        run_uop(u, 0, 0);

        run_bubble();

        // Ack coinciding with the next load: A retires, B latches at the edge.
        a = rand_uop();
        a.st = 1; a.ld_gpr1 = 1; a.ds = DS_DWORD; a.dr1 = 3'd1; a.repne = 0; a.cs = 0;
        b = rand_uop();
        b.st = 0; b.ld_gpr1 = 1; b.ds = DS_WORD; b.dr1 = 3'd2; b.repne = 0; b.cs = 0;
        @(negedge CLK);
        drive_next(a);
        WB_ld_latches = 1'b1;
        @(negedge CLK);
        WB_ld_latches = 1'b0;
        #1;
        check_cycle(a, 0, 1, 1, 0);
        @(negedge CLK);
        drive_next(b);
        WB_ld_latches = 1'b1;
        dcache_wr_ack = 1'b1;
        #1;
        check_cycle(a, 1, 1, 0, 0);
        model_retire(a);
        @(negedge CLK);
        WB_ld_latches = 1'b0;
        dcache_wr_ack = 1'b0;
        #1;
        check_cycle(b, 1, 0, 0, 0);
        model_retire(b);
        @(negedge CLK);
        #1;
        check_cycle(b, 0, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            u = rand_uop();
            if ($urandom_range(0, 7) == 0) run_bubble();
            run_uop(u, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Reset while a store waits for its ack.
        a = rand_uop();
        a.st = 1; a.ld_gpr1 = 1; a.ld_gpr2 = 1; a.ld_mm = 1; a.ds = DS_DWORD;
        @(negedge CLK);
        drive_next(a);
        WB_ld_latches = 1'b1;
        @(negedge CLK);
        WB_ld_latches = 1'b0;
        #1;
        check_cycle(a, 0, 1, 1, 0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rstw_we1", 64'(gpr_we1), 64'(0));
        check("rstw_we2", 64'(gpr_we2), 64'(0));
        check("rstw_mm_we", 64'(mm_we), 64'(0));
        @(negedge CLK);
        RST = 1'b0;
        eflags_m = EFLAGS_RESET;
        saved_m  = 32'h0;
        #1;
        check("rstw_req", 64'(dcache_wr_req), 64'(0));
        check("rstw_stall", 64'(WB_stall), 64'(0));
        check("rstw_we1_after", 64'(gpr_we1), 64'(0));
        check("rstw_flags_fwd", 64'(flags_dataforwarded), 64'(eflags_m));
        check("rstw_saved", 64'(saved_count), 64'(saved_m));
        @(negedge CLK);
        #1;
        check("rstw_req_idle", 64'(dcache_wr_req), 64'(0));
        check("rstw_we1_idle", 64'(gpr_we1), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
